// File: rtl/data_break_responder.sv
// Data-break responder: one peripheral word transfer per granted break (IDLE -> DB0 -> DB1 -> DB2).
// Define DB_INCREMENT_EN to add the db_inc read-increment-write transfer and its db_overflow flag.
module data_break_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        db_read,
  input  logic        db_write,
  input  logic [0:11] db_addr,
  input  logic [0:2]  db_field,
  input  logic [0:11] db_wdata,
  input  logic        break_ok,
  input  logic [0:11] mem_rdata,
  output logic [0:14] mem_addr,
  output logic [0:11] mem_wdata,
  output logic        mem_we,
  output logic [0:11] db_rdata,
  output logic        db_ack,
  output logic [1:0]  db_state,
  output logic        busy
`ifdef DB_INCREMENT_EN
  ,
  input  logic        db_inc,
  output logic        db_overflow
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DB0  = 2'd1;
  localparam logic [1:0] S_DB1  = 2'd2;
  localparam logic [1:0] S_DB2  = 2'd3;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INC   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [0:11] addr_q, addr_d;
  logic [0:2]  field_q, field_d;
  logic [0:11] wdata_q, wdata_d;
  logic [0:11] rdata_q, rdata_d;
  logic        inc_req;

`ifdef DB_INCREMENT_EN
  assign inc_req = db_inc;
`else
  assign inc_req = 1'b0;
`endif

  // NOTE: every always_comb output takes its held value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    field_d = field_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if ((db_read || db_write || inc_req) && break_ok) begin
          state_d = S_DB0;
          addr_d  = db_addr;
          field_d = db_field;
          wdata_d = db_wdata;
          if (inc_req)       op_d = OP_INC;
          else if (db_write) op_d = OP_WRITE;
          else               op_d = OP_READ;
        end
      end
      S_DB0: state_d = S_DB1;
      S_DB1: begin
        state_d = S_DB2;
        // Memory data for the DB0 address is valid here; capture it so DB2 can present it.
        if (op_q == OP_READ)     rdata_d = mem_rdata;
        else if (op_q == OP_INC) rdata_d = mem_rdata + 12'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      field_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      field_q <= field_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_addr  = {field_q, addr_q};
  assign mem_we    = ((state_q == S_DB1) && (op_q == OP_WRITE)) ||
                     ((state_q == S_DB2) && (op_q == OP_INC));
  assign mem_wdata = (op_q == OP_INC) ? rdata_q : wdata_q;
  assign db_rdata  = rdata_q;
  assign db_ack    = (state_q == S_DB2);
  assign db_state  = state_q;
  assign busy      = (state_q != S_IDLE);

`ifdef DB_INCREMENT_EN
  assign db_overflow = db_ack && (op_q == OP_INC) && (rdata_q == 12'd0);
`endif

endmodule

// File: tb/tb_data_break_responder.sv
// Directed bench for data_break_responder: vector table of single transfers plus
// hand-written sequences for break holdoff, back-to-back requests and reset mid-transfer.
module tb_data_break_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        db_read, db_write, break_ok;
  logic [0:11] db_addr, db_wdata, mem_rdata;
  logic [0:2]  db_field;
  logic [0:14] mem_addr;
  logic [0:11] mem_wdata, db_rdata;
  logic        mem_we, db_ack, busy;
  logic [1:0]  db_state;
`ifdef DB_INCREMENT_EN
  logic        db_inc, db_overflow;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  data_break_responder dut (
    .clk      (clk),
    .reset    (reset),
    .db_read  (db_read),
    .db_write (db_write),
    .db_addr  (db_addr),
    .db_field (db_field),
    .db_wdata (db_wdata),
    .break_ok (break_ok),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .db_rdata (db_rdata),
    .db_ack   (db_ack),
    .db_state (db_state),
    .busy     (busy)
`ifdef DB_INCREMENT_EN
    ,
    .db_inc     (db_inc),
    .db_overflow(db_overflow)
`endif
  );

  // Synchronous-read memory; the preload port lets the bench seed words while the DUT is idle.
  logic [0:11] mem [0:32767];
  logic        pre_we = 1'b0;
  logic [0:14] pre_addr = '0;
  logic [0:11] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [0:14] a, input logic [0:11] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic drop_request();
    db_read  = 1'b0;
    db_write = 1'b0;
`ifdef DB_INCREMENT_EN
    db_inc   = 1'b0;
`endif
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [0:11] addr;
    logic [0:2]  field;
    logic [0:11] wdata;
    logic [0:11] mem_word;
    logic [0:14] exp_addr;
    logic        exp_we;
    logic [0:11] exp_rdata;
    logic [0:11] exp_mem;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int bad;
    int acks;

    // rd, wr, addr, field, wdata, mem_word, exp_addr, exp_we, exp_rdata, exp_mem (all octal)
    vecs[0] = '{1'b0, 1'b1, 12'o0200, 3'o3, 12'o1234, 12'o0000, 15'o30200, 1'b1, 12'o0000, 12'o1234};
    vecs[1] = '{1'b1, 1'b0, 12'o7777, 3'o0, 12'o0000, 12'o5252, 15'o07777, 1'b0, 12'o5252, 12'o5252};
    vecs[2] = '{1'b1, 1'b1, 12'o0001, 3'o7, 12'o4321, 12'o1111, 15'o70001, 1'b1, 12'o5252, 12'o4321};
    vecs[3] = '{1'b1, 1'b0, 12'o0000, 3'o5, 12'o3333, 12'o0707, 15'o50000, 1'b0, 12'o0707, 12'o0707};
    vecs[4] = '{1'b0, 1'b1, 12'o7777, 3'o7, 12'o7777, 12'o0000, 15'o77777, 1'b1, 12'o0707, 12'o7777};

    reset    = 1'b0;
    db_read  = 1'b0;
    db_write = 1'b0;
    break_ok = 1'b0;
    db_addr  = '0;
    db_field = '0;
    db_wdata = '0;
`ifdef DB_INCREMENT_EN
    db_inc   = 1'b0;
`endif
    #3;
    check("reset_state", 32'(db_state), 32'd0);
    check("reset_outputs", 32'({mem_addr, mem_wdata, mem_we, db_rdata, db_ack, busy}), 32'd0);
    step();
    reset = 1'b1;
    step();

    foreach (vecs[i]) begin
      preload({vecs[i].field, vecs[i].addr}, vecs[i].mem_word);
      db_read  = vecs[i].rd;
      db_write = vecs[i].wr;
      db_addr  = vecs[i].addr;
      db_field = vecs[i].field;
      db_wdata = vecs[i].wdata;
      break_ok = 1'b1;
      step();
      check($sformatf("v%0d_db0_state", i), 32'(db_state), 32'd1);
      check($sformatf("v%0d_db0_we_ack", i), 32'({mem_we, db_ack, busy}), 32'b001);
      // Inputs change after acceptance; the transfer must use the latched copies.
      drop_request();
      db_addr  = ~vecs[i].addr;
      db_field = ~vecs[i].field;
      db_wdata = ~vecs[i].wdata;
      break_ok = 1'b0;
      step();
      check($sformatf("v%0d_db1_state", i), 32'(db_state), 32'd2);
      check($sformatf("v%0d_db1_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_db1_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) check($sformatf("v%0d_db1_wdata", i), 32'(mem_wdata), 32'(vecs[i].wdata));
      step();
      check($sformatf("v%0d_db2_state", i), 32'(db_state), 32'd3);
      check($sformatf("v%0d_db2_ack_we", i), 32'({db_ack, mem_we}), 32'b10);
      check($sformatf("v%0d_db2_rdata", i), 32'(db_rdata), 32'(vecs[i].exp_rdata));
      step();
      check($sformatf("v%0d_idle", i), 32'({db_state, db_ack, busy}), 32'd0);
      check($sformatf("v%0d_rdata_hold", i), 32'(db_rdata), 32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_mem", i), 32'(mem[vecs[i].exp_addr]), 32'(vecs[i].exp_mem));
    end

    // Read request held without a break grant must not start a transfer.
    db_read  = 1'b1;
    db_addr  = 12'o0042;
    db_field = 3'o1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (db_state != 2'd0 || busy !== 1'b0) bad++;
    end
    check("holdoff_idle_cycles", 32'(bad), 32'd0);
    break_ok = 1'b1;
    step();
    check("holdoff_grant_db0", 32'(db_state), 32'd1);
    drop_request();
    break_ok = 1'b0;
    step();
    step();
    step();
    check("holdoff_done", 32'({db_state, busy}), 32'd0);

    // Request held through DB2: IDLE for one edge, then a second transfer starts.
    db_write = 1'b1;
    db_addr  = 12'o0100;
    db_field = 3'o1;
    db_wdata = 12'o0055;
    break_ok = 1'b1;
    step();
    step();
    step();
    check("b2b_first_ack", 32'({db_state, db_ack}), 32'b111);
    step();
    check("b2b_idle_between", 32'({db_state, db_ack}), 32'd0);
    step();
    check("b2b_second_db0", 32'(db_state), 32'd1);
    drop_request();
    break_ok = 1'b0;
    step();
    step();
    step();
    check("b2b_done", 32'({db_state, busy}), 32'd0);

    // Reset asserted during DB1 abandons the write; the held request restarts after release.
    db_write = 1'b1;
    db_addr  = 12'o0300;
    db_field = 3'o2;
    db_wdata = 12'o6666;
    break_ok = 1'b1;
    step();
    step();
    check("rst_db1_we", 32'({db_state, mem_we}), 32'b101);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_outputs",
          32'({db_state, busy, db_ack, mem_we}), 32'd0);
    check("rst_async_data", 32'({mem_addr, mem_wdata}), 32'd0);
    check("rst_async_rdata", 32'(db_rdata), 32'd0);
    acks = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (db_ack !== 1'b0 || db_state != 2'd0) acks++;
    end
    check("rst_no_ack", 32'(acks), 32'd0);
    reset = 1'b1;
    step();
    check("rst_restart_db0", 32'(db_state), 32'd1);
    step();
    check("rst_restart_db1", 32'({db_state, mem_we}), 32'b101);
    check("rst_restart_addr", 32'(mem_addr), 32'(15'o20300));
    drop_request();
    step();
    check("rst_restart_db2", 32'({db_state, db_ack}), 32'b111);
    step();
    check("rst_restart_idle", 32'({db_state, busy}), 32'd0);
    check("rst_restart_mem", 32'(mem[15'o20300]), 32'(12'o6666));

`ifdef DB_INCREMENT_EN
    // Increment of 7777 wraps to 0000 and flags overflow alongside the ack.
    preload(15'o40123, 12'o7777);
    db_inc   = 1'b1;
    db_read  = 1'b1;
    db_addr  = 12'o0123;
    db_field = 3'o4;
    break_ok = 1'b1;
    step();
    drop_request();
    break_ok = 1'b0;
    step();
    check("inc_db1_we", 32'({db_state, mem_we}), 32'b100);
    step();
    check("inc_db2_we_ack_ovf", 32'({mem_we, db_ack, db_overflow}), 32'b111);
    check("inc_db2_wdata", 32'(mem_wdata), 32'd0);
    check("inc_db2_rdata", 32'(db_rdata), 32'd0);
    step();
    check("inc_idle_ovf", 32'({db_state, db_overflow}), 32'd0);
    check("inc_mem", 32'(mem[15'o40123]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
